// File: rtl/divider_pkg.sv
// Shared execute-stage definitions: instruction/data types, M-extension funct3
// codes and the divider state encoding.
package divider_pkg;

  typedef logic [31:0] data_t;

  // RV32 R-type instruction layout as delivered by the decoder.
  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_t;

  // Result driven when an operation has no meaningful value.
  localparam data_t NULL = 32'h0000_0000;

  // Multiplier funct3 codes.
  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;

  // Divider funct3 codes.
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  // One quotient bit per iteration.
  localparam int unsigned DIV_ITER = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring division iteration, purely combinational.
module div_step
  import divider_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] dvd,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] dvd_next,
  output logic            q_bit
);

  logic [XLEN:0] rem_shift;
  logic [XLEN:0] diff;

  // Shift the next dividend bit into the remainder and trial-subtract the divisor.
  // The shifted remainder keeps rem's MSB so divisors >= 2^(XLEN-1) still work;
  // a borrow out of the 33-bit subtract means the divisor did not fit.
  always_comb begin
    rem_shift = {rem, dvd[XLEN-1]};
    diff      = rem_shift - {1'b0, divisor};
    q_bit     = ~diff[XLEN];
    rem_next  = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    dvd_next  = {dvd[XLEN-2:0], 1'b0};
  end

endmodule

// File: rtl/divider.sv
// Iterative RV32M divide unit (DIV/DIVU/REM/REMU). Restoring radix-2, one
// quotient bit per cycle, with single-cycle results for divide-by-zero, signed
// overflow and non-divide funct3 codes.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  instr_t          instr,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic            start,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] c_out
);

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       state;
  logic [2:0]       funct3_q;
  logic             neg_q;
  logic             neg_r;
  logic [XLEN-1:0]  dvd_q;      // dividend on entry, quotient once iterations finish
  logic [XLEN-1:0]  divisor_q;
  logic [XLEN-1:0]  rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic [2:0]      f3;
  logic            is_signed;
  logic            legal;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            overflow;
  logic            fast;
  logic [XLEN-1:0] fast_res;

  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] dvd_next;
  logic            q_bit;
  logic [XLEN-1:0] dvd_fill;
  logic [XLEN-1:0] calc_res;

  // Only funct3 matters here; the rest of the instruction is intentionally ignored.
  logic unused_instr;
  assign unused_instr = ^{instr.funct7, instr.rs2, instr.rs1, instr.rd, instr.opcode};

  // Decode the incoming request and precompute operand magnitudes.
  always_comb begin
    f3        = instr.funct3;
    is_signed = (f3 == DIV) || (f3 == REM);
    legal     = (f3 == DIV) || (f3 == DIVU) || (f3 == REM) || (f3 == REMU);
    a_neg     = is_signed & a_in[XLEN-1];
    b_neg     = is_signed & b_in[XLEN-1];
    a_abs     = a_neg ? -a_in : a_in;
    b_abs     = b_neg ? -b_in : b_in;
    overflow  = is_signed && (a_in == MinNeg) && (b_in == '1);
  end

  // Architectural corner cases resolved without iterating; funct3[1] marks REM/REMU.
  always_comb begin
    fast     = 1'b0;
    fast_res = XLEN'(NULL);
    if (!legal) begin
      fast     = 1'b1;
      fast_res = XLEN'(NULL);
    end else if (b_in == '0) begin
      fast     = 1'b1;
      fast_res = f3[1] ? a_in : '1;
    end else if (overflow) begin
      fast     = 1'b1;
      fast_res = f3[1] ? '0 : MinNeg;
    end
  end

  div_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem     (rem_q),
    .dvd     (dvd_q),
    .divisor (divisor_q),
    .rem_next(rem_next),
    .dvd_next(dvd_next),
    .q_bit   (q_bit)
  );

  // Quotient bit fills the slot vacated by the dividend shift; sign-correct the
  // final result as it leaves the last iteration.
  always_comb begin
    dvd_fill = dvd_next | {{(XLEN-1){1'b0}}, q_bit};
    if ((funct3_q == REM) || (funct3_q == REMU)) begin
      calc_res = neg_r ? -rem_next : rem_next;
    end else begin
      calc_res = neg_q ? -dvd_fill : dvd_fill;
    end
  end

  // Control FSM with registered busy/done/c_out; flush overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      c_out     <= '0;
      funct3_q  <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dvd_q     <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            funct3_q  <= f3;
            neg_q     <= a_neg ^ b_neg;
            neg_r     <= a_neg;
            dvd_q     <= a_abs;
            divisor_q <= b_abs;
            rem_q     <= '0;
            cnt_q     <= CNT_W'(DIV_ITER - 1);
            if (fast) begin
              c_out <= fast_res;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_next;
          dvd_q <= dvd_fill;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            c_out <= calc_res;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed, table-driven bench for the iterative divider.
module tb_divider;
  import divider_pkg::*;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          fast;
    string       name;
  } vec_t;

  logic        clk;
  logic        rst_n;
  instr_t      instr;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        start;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] c_out;

  int n_checks;
  int n_fail;

  divider #(
    .XLEN (32),
    .CNT_W(5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .instr(instr),
    .a_in (a_in),
    .b_in (b_in),
    .start(start),
    .flush(flush),
    .busy (busy),
    .done (done),
    .c_out(c_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp, input bit fast, input string name);
    vec_t v;
    v.f3 = f3; v.a = a; v.b = b; v.exp = exp; v.fast = fast; v.name = name;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    instr        = '0;
    instr.funct3 = f3;
    a_in         = a;
    b_in         = b;
  endtask

  // Issue one op, wait (bounded) for done. lat counts edges after the accept
  // edge until done is seen; bcnt counts busy cycles before done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bcnt,
                        output logic after);
    @(negedge clk);
    drive(f3, a, b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    res = c_out;
    @(posedge clk); #1;
    after = done | busy;
  endtask

  vec_t        vecs[$];
  logic [31:0] res;
  int          lat;
  int          bcnt;
  logic        after;
  logic [31:0] last_res;
  int          ev;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    drive(3'b000, '0, '0);

    vecs.push_back(mk(DIV,  32'd20,       32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0, "div_20_m3"));
    vecs.push_back(mk(REM,  32'd20,       32'hFFFF_FFFD, 32'd2,         1'b0, "rem_20_m3"));
    vecs.push_back(mk(REM,  32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE, 1'b0, "rem_m20_3"));
    vecs.push_back(mk(REMU, 32'hFFFF_FFFF, 32'd16,       32'd15,        1'b0, "remu_max_16"));
    vecs.push_back(mk(DIVU, 32'hFFFF_FFFF, 32'd16,       32'h0FFF_FFFF, 1'b0, "divu_max_16"));
    vecs.push_back(mk(DIVU, 32'd7,        32'd0,         32'hFFFF_FFFF, 1'b1, "divu_by0"));
    vecs.push_back(mk(REM,  32'd7,        32'd0,         32'd7,         1'b1, "rem_by0"));
    vecs.push_back(mk(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf"));
    vecs.push_back(mk(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1'b1, "rem_ovf"));
    vecs.push_back(mk(DIV,  32'd5,        32'd0,         32'hFFFF_FFFF, 1'b1, "div_by0"));
    vecs.push_back(mk(MUL,  32'd5,        32'd3,         32'd0,         1'b1, "illegal_f3"));
    vecs.push_back(mk(DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, "div_m7_2"));
    vecs.push_back(mk(REM,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0, "rem_m7_2"));
    vecs.push_back(mk(DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,        1'b0, "divu_bigdiv"));
    vecs.push_back(mk(REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0, "remu_bigdiv"));
    vecs.push_back(mk(DIV,  32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0, "div_min_1"));
    vecs.push_back(mk(REMU, 32'd0,        32'd5,         32'd0,         1'b0, "remu_zero"));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",  {31'd0, busy}, 32'd0);
    chk("reset_done",  {31'd0, done}, 32'd0);
    chk("reset_c_out", c_out,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven ops; consecutive calls also exercise back-to-back starts
    last_res = '0;
    foreach (vecs[i]) begin
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, bcnt, after);
      chk({vecs[i].name, "_c_out"},   res,            vecs[i].exp);
      chk({vecs[i].name, "_latency"}, lat,            vecs[i].fast ? 32'd0 : 32'd32);
      chk({vecs[i].name, "_busy"},    bcnt,           vecs[i].fast ? 32'd0 : 32'd32);
      chk({vecs[i].name, "_1cycle"},  {31'd0, after}, 32'd0);
      last_res = vecs[i].exp;
    end

    // Flush mid-CALC: no done, c_out kept
    @(negedge clk);
    drive(DIV, 32'd1000, 32'd3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_after", {31'd0, busy}, 32'd0);
    ev = 0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) ev++;
      @(posedge clk); #1;
    end
    chk("flush_no_done", ev,    32'd0);
    chk("flush_c_out",   c_out, last_res);

    // start together with flush in IDLE is ignored
    @(negedge clk);
    drive(DIVU, 32'd7, 32'd0);
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    ev = 0;
    repeat (3) begin
      if (done === 1'b1 || busy === 1'b1) ev++;
      @(posedge clk); #1;
    end
    chk("start_flush_ignored", ev, 32'd0);

    // Start while busy (T+5) and while in DONE are both ignored
    @(negedge clk);
    drive(DIV, 32'd20, 32'hFFFF_FFFD);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    repeat (4) begin
      @(posedge clk); #1;
      lat++;
    end
    drive(DIVU, 32'd100, 32'd7);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat++;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("busy_start_latency", lat,   32'd32);
    chk("busy_start_c_out",   c_out, 32'hFFFF_FFFA);
    drive(DIVU, 32'd7, 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ev = 0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) ev++;
      @(posedge clk); #1;
    end
    chk("no_queued_start", ev, 32'd0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    drive(DIVU, 32'hFFFF_FFFF, 32'd16);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("rst_busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_busy",  {31'd0, busy}, 32'd0);
    chk("rst_async_done",  {31'd0, done}, 32'd0);
    chk("rst_async_c_out", c_out,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // After reset, then a back-to-back start in the cycle after done
    run_op(DIVU, 32'd100, 32'd7, res, lat, bcnt, after);
    chk("post_rst_c_out",   res, 32'd14);
    chk("post_rst_latency", lat, 32'd32);
    run_op(DIVU, 32'd1000, 32'd10, res, lat, bcnt, after);
    chk("b2b_c_out",   res, 32'd100);
    chk("b2b_latency", lat, 32'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
